// File: rtl/score_register.sv
// score_register
//
// Clocked score-holding register for the scoring path. In load mode it
// captures the score presented on I at every rising edge of C; in accumulate
// mode it adds I into the held score and saturates at the all-ones value
// instead of wrapping. O comes straight from the state register, so there is
// no combinational path from I to O.
//
// Parameters:
//   WIDTH       - data width of I and O
//   ACCUMULATE  - 0 = load I each edge, 1 = saturating add of I into O
//   RESET_VALUE - value held on O while INIT is low
//
// Ports:
//   C    - clock, all updates on the rising edge
//   INIT - asynchronous active-low reset (0 = reset asserted)
//   I    - next score (load mode) or score increment (accumulate mode)
//   O    - registered score

module score_register #(
  parameter int                 WIDTH       = 8,
  parameter bit                 ACCUMULATE  = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             C,
  input  logic             INIT,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O
);

  logic [WIDTH-1:0] nextScore;

  generate
    if (ACCUMULATE) begin : gAccumulate
      // The sum is formed one bit wider than the score so that the carry out
      // tells us the true total no longer fits; in that case the score pins at
      // the maximum rather than wrapping back to a small number.
      logic [WIDTH:0] sum;

      always_comb begin
        sum       = {1'b0, O} + {1'b0, I};
        nextScore = sum[WIDTH-1:0];
        if (sum[WIDTH]) begin
          nextScore = '1;
        end
      end
    end else begin : gLoad
      // Plain load: the next score is whatever is presented at the edge.
      always_comb begin
        nextScore = I;
      end
    end
  endgenerate

  // Score state register. Reset is asynchronous, so pulling INIT low clears
  // the score at once and any clock edges while it stays low are ignored.
  // Release is not synchronised here; the surrounding system provides that.
  always_ff @(posedge C or negedge INIT) begin
    if (!INIT) begin
      O <= RESET_VALUE;
    end else begin
      O <= nextScore;
    end
  end

endmodule

// File: tb/tb_score_register.sv
// tb_score_register
//
// Drives one load-mode and one accumulate-mode score_register from a shared
// clock and reset. Expected scores come from a reference model in the bench:
// load mode remembers the last value presented at a qualified edge, and
// accumulate mode keeps a running integer total clipped at 255.

module tb_score_register;

  logic       C = 1'b0;
  logic       INIT = 1'b1;
  logic [7:0] iLoad = 8'h00;
  logic [7:0] iAcc = 8'h00;
  logic [7:0] oLoad;
  logic [7:0] oAcc;

  int vectors = 0;
  int miscompares = 0;
  int expLoad = 0;
  int expAcc = 0;

  always #5 C = ~C;

  score_register #(.WIDTH(8), .ACCUMULATE(1'b0), .RESET_VALUE(8'h00)) dutLoad (
    .C    (C),
    .INIT (INIT),
    .I    (iLoad),
    .O    (oLoad)
  );

  score_register #(.WIDTH(8), .ACCUMULATE(1'b1), .RESET_VALUE(8'h00)) dutAcc (
    .C    (C),
    .INIT (INIT),
    .I    (iAcc),
    .O    (oAcc)
  );

  // Compare one observed score with the model's value.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input int expected);
    logic [7:0] expv;
    expv = expected[7:0];
    vectors++;
    assert (observed === expv)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expv);
    end
  endtask

  task automatic checkBoth(input string tag);
    checkOutput({tag, "_load"}, oLoad, expLoad);
    checkOutput({tag, "_acc"}, oAcc, expAcc);
  endtask

  // Present inputs, take one rising edge, update the model and return 1ns
  // after the edge with C still high.
  task automatic applyStimulus(input logic [7:0] loadVal, input logic [7:0] accVal);
    int total;
    iLoad = loadVal;
    iAcc  = accVal;
    @(posedge C);
    if (INIT) begin
      expLoad = loadVal;
      total   = expAcc + accVal;
      expAcc  = (total > 255) ? 255 : total;
    end
    #1;
  endtask

  task automatic modelReset();
    expLoad = 0;
    expAcc  = 0;
  endtask

  initial begin
    int r;
    logic [7:0] rl;
    logic [7:0] ra;

    // Power-up reset held for 100ns with clock running and I = 1.
    iLoad = 8'h01;
    iAcc  = 8'h01;
    #1 INIT = 1'b0;
    modelReset();
    for (int k = 0; k < 5; k++) begin
      #20;
      checkBoth("powerup_reset");
    end

    // Release does not change O.
    @(negedge C);
    INIT = 1'b1;
    #1 checkBoth("release_no_change");

    // First edge after release loads 1, accumulator goes to 1.
    applyStimulus(8'h01, 8'h01);
    checkBoth("first_edge");

    // Changing I while C is high has no effect.
    iLoad = 8'hFF;
    #1 checkOutput("i_change_c_high", oLoad, expLoad);

    // Next edge loads FF; accumulator 2.
    applyStimulus(8'hFF, 8'h01);
    checkBoth("second_edge");

    // Toggle I between edges with no clock edge.
    iLoad = 8'h10;
    #1 checkOutput("between_edges_10", oLoad, expLoad);
    iLoad = 8'h20;
    #1 checkOutput("between_edges_20", oLoad, expLoad);
    applyStimulus(iLoad, 8'h0A);
    checkBoth("edge_takes_present_i");

    // Accumulator saturates at FF rather than wrapping to 0B.
    applyStimulus(8'hFF, 8'hFF);
    checkBoth("acc_saturate");
    applyStimulus(8'hFF, 8'h01);
    checkBoth("acc_stay_saturated");

    // Async reset mid-operation with C static high.
    INIT = 1'b0;
    modelReset();
    #1 checkBoth("async_reset_immediate");
    iLoad = 8'h55;
    iAcc  = 8'h03;
    @(posedge C);
    @(posedge C);
    #1 checkBoth("edges_ignored_in_reset");
    #1 INIT = 1'b1;
    #1 checkBoth("release_after_midop");
    applyStimulus(8'h55, 8'h03);
    checkBoth("load_after_midop_reset");

    // Reset asserted in the same timestep as a rising edge.
    iLoad = 8'h33;
    iAcc  = 8'h07;
    @(posedge C);
    INIT = 1'b0;
    modelReset();
    #1 checkBoth("reset_edge_coincide");
    #2 INIT = 1'b1;
    #1 checkBoth("release_after_coincide");

    // Randomised phase, including I = 0 holds and occasional resets.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        INIT = 1'b0;
        modelReset();
        #1 checkBoth("rand_async_reset");
        #1 INIT = 1'b1;
      end else begin
        rl = 8'($urandom);
        if (r < 4)
          ra = 8'h00;
        else if (r < 9)
          ra = 8'($urandom_range(1, 15));
        else
          ra = 8'($urandom);
        applyStimulus(rl, ra);
        checkBoth("rand_step");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
